// File: rtl/vga_bounce_sprite_if.sv
// Scan-to-video bus for the bouncing-sprite pixel stage.
//   sx, sy, de_in, hsync_in, vsync_in : scan position, data enable and syncs (syncs active-low)
//   video_r/g/b, video_h_sync/v_sync  : RGB565 colour and the realigned syncs
// The master drives the scan side and receives video. The slave is the pixel stage.
interface vga_bounce_sprite_if;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       de_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [4:0] video_r;
  logic [5:0] video_g;
  logic [4:0] video_b;
  logic       video_h_sync;
  logic       video_v_sync;

  modport master (
    output sx, sy, de_in, hsync_in, vsync_in,
    input  video_r, video_g, video_b, video_h_sync, video_v_sync
  );

  modport slave (
    input  sx, sy, de_in, hsync_in, vsync_in,
    output video_r, video_g, video_b, video_h_sync, video_v_sync
  );
endinterface

// File: rtl/vga_bounce_sprite.sv
// Pixel generation: a solid sprite on a flat background. The sprite bounces off the screen
// edges and moves once per frame, in vertical blanking only.
//   clk_pix    : pixel clock
//   rst_pix    : synchronous active-high reset
//   enable     : 1 = sprite moves at each frame event, 0 = position frozen
//   vif        : scan inputs in, RGB565 and syncs out (2-cycle latency for all of them)
//   frame_tick : one-cycle pulse after the frame event (sx==0, sy==V_RES)
module vga_bounce_sprite #(
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480,
  parameter int unsigned SPR_W     = 32,
  parameter int unsigned SPR_H     = 32,
  parameter int unsigned STEP      = 1,
  parameter logic [15:0] BG_COLOR  = 16'h0000,
  parameter logic [15:0] SPR_COLOR = 16'hF800
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                enable,
  vga_bounce_sprite_if.slave  vif,
  output logic                frame_tick
);

  localparam int unsigned LIM_X = H_RES - SPR_W;
  localparam int unsigned LIM_Y = V_RES - SPR_H;

  logic [9:0]  x_pos, y_pos;
  logic        dir_x, dir_y;          // 1 = moving towards 0
  logic [9:0]  nx, ny;
  logic        ndx, ndy;
  logic        fev, hit;
  logic        hit1, de1, hs1, vs1;
  logic [15:0] rgb;
  logic        hs2, vs2;

  // First pixel of the first blanking line; the only point where the sprite may move.
  assign fev = (vif.sx == 10'd0) && (vif.sy == 10'(V_RES));

  // Next position on each axis, clamped at the edges with a direction flip.
  always_comb begin
    nx  = x_pos;
    ndx = dir_x;
    ny  = y_pos;
    ndy = dir_y;
    if (!dir_x) begin
      if ((11'(x_pos) + 11'(STEP)) >= 11'(LIM_X)) begin
        nx  = 10'(LIM_X);
        ndx = 1'b1;
      end else begin
        nx = x_pos + 10'(STEP);
      end
    end else if (11'(x_pos) <= 11'(STEP)) begin
      nx  = 10'd0;
      ndx = 1'b0;
    end else begin
      nx = x_pos - 10'(STEP);
    end
    if (!dir_y) begin
      if ((11'(y_pos) + 11'(STEP)) >= 11'(LIM_Y)) begin
        ny  = 10'(LIM_Y);
        ndy = 1'b1;
      end else begin
        ny = y_pos + 10'(STEP);
      end
    end else if (11'(y_pos) <= 11'(STEP)) begin
      ny  = 10'd0;
      ndy = 1'b0;
    end else begin
      ny = y_pos - 10'(STEP);
    end
  end

  // Sprite bounds compared at 11 bits so that x_pos+SPR_W cannot wrap.
  assign hit = (11'(vif.sx) >= 11'(x_pos)) && (11'(vif.sx) < (11'(x_pos) + 11'(SPR_W))) &&
               (11'(vif.sy) >= 11'(y_pos)) && (11'(vif.sy) < (11'(y_pos) + 11'(SPR_H)));

  // Position state, frame tick and the two pipeline stages.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      x_pos      <= '0;
      y_pos      <= '0;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      frame_tick <= 1'b0;
      hit1       <= 1'b0;
      de1        <= 1'b0;
      hs1        <= 1'b1;
      vs1        <= 1'b1;
      rgb        <= '0;
      hs2        <= 1'b1;
      vs2        <= 1'b1;
    end else begin
      frame_tick <= fev;
      if (fev && enable) begin
        x_pos <= nx;
        dir_x <= ndx;
        y_pos <= ny;
        dir_y <= ndy;
      end
      hit1 <= hit;
      de1  <= vif.de_in;
      hs1  <= vif.hsync_in;
      vs1  <= vif.vsync_in;
      rgb  <= de1 ? (hit1 ? SPR_COLOR : BG_COLOR) : 16'h0000;
      hs2  <= hs1;
      vs2  <= vs1;
    end
  end

  assign vif.video_r      = rgb[15:11];
  assign vif.video_g      = rgb[10:5];
  assign vif.video_b      = rgb[4:0];
  assign vif.video_h_sync = hs2;
  assign vif.video_v_sync = vs2;

endmodule
